// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer
//   Streams a MSG_LEN-byte message template into a uart_tx byte interface.
//   A window of FIELD_DIGITS bytes starting at FIELD_POS is replaced by the
//   uppercase ASCII-hex rendering of a snapshot of i_field_value, taken when
//   the message starts. Messages are started by a periodic tick and/or a
//   manual trigger. One trigger arriving while busy is remembered. A tick
//   arriving while busy is dropped and counted as an overrun.
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_periodic_en      enables the period counter and periodic sends
//   i_trigger          single-cycle request for one message
//   i_field_value      value rendered into the hex field
//   o_tx_data          byte to uart_tx; held stable while o_tx_data_valid is high
//   o_tx_data_valid    byte valid
//   i_tx_data_ready    uart_tx can accept
//   o_busy             message in progress
//   o_msg_done         one-cycle pulse after the last byte is accepted
//   o_msg_count        completed messages; wraps at 0xFFFF
//   o_overrun_cnt      ticks dropped while busy; saturates at 255
module uart_msg_sequencer #(
  parameter int                   PERIOD_CYCLES = 27_000_000,
  parameter int                   MSG_LEN       = 14,
  parameter logic [8*MSG_LEN-1:0] MSG_TEMPLATE  = "CNT=00000000\r\n",
  parameter int                   FIELD_POS     = 4,
  parameter int                   FIELD_DIGITS  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_periodic_en,
  input  logic                      i_trigger,
  input  logic [4*FIELD_DIGITS-1:0] i_field_value,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_data_valid,
  input  logic                      i_tx_data_ready,
  output logic                      o_busy,
  output logic                      o_msg_done,
  output logic [15:0]               o_msg_count,
  output logic [7:0]                o_overrun_cnt
);

  localparam int FW = 4*FIELD_DIGITS;
  localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;

  if (FIELD_POS + FIELD_DIGITS > MSG_LEN) begin : g_bad_field
    $error("uart_msg_sequencer: hex field runs past the end of the message");
  end
  if (PERIOD_CYCLES < 2) begin : g_bad_period
    $error("uart_msg_sequencer: PERIOD_CYCLES must be at least 2");
  end
  if (MSG_LEN < 1 || MSG_LEN > 255) begin : g_bad_len
    $error("uart_msg_sequencer: MSG_LEN must be 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t         r_state;
  logic [PW-1:0]  r_per_cnt;
  logic [7:0]     r_idx;
  logic [FW-1:0]  r_snap;
  logic           r_pending;
  logic           r_busy;
  logic           r_valid;
  logic           r_done;
  logic [7:0]     r_tx_data;
  logic [15:0]    r_msg_count;
  logic [7:0]     r_overrun;

  logic w_tick, w_req, w_accept, w_last;

  // Byte idx of the outgoing message. Hex digits are emitted MS nibble first.
  function automatic logic [7:0] char_at(input logic [7:0] idx, input logic [FW-1:0] snap);
    logic [7:0] c;
    logic [3:0] nib;
    int         k;
    c = MSG_TEMPLATE[8*(MSG_LEN-1-int'(idx)) +: 8];
    if (int'(idx) >= FIELD_POS && int'(idx) < FIELD_POS + FIELD_DIGITS) begin
      k   = FIELD_DIGITS - 1 - (int'(idx) - FIELD_POS);
      nib = snap[4*k +: 4];
      c   = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end
    return c;
  endfunction

  assign w_tick   = i_periodic_en && (r_per_cnt == PW'(PERIOD_CYCLES-1));
  assign w_req    = i_trigger | w_tick;
  assign w_accept = r_valid & i_tx_data_ready;
  assign w_last   = (r_idx == 8'(MSG_LEN-1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_per_cnt   <= '0;
      r_idx       <= '0;
      r_snap      <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_tx_data   <= '0;
      r_msg_count <= '0;
      r_overrun   <= '0;
    end else begin
      if (!i_periodic_en || w_tick) r_per_cnt <= '0;
      else                          r_per_cnt <= r_per_cnt + 1'b1;

      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_req) begin
          // trigger and tick together here start exactly one message
          r_snap    <= i_field_value;
          r_idx     <= '0;
          r_tx_data <= char_at(8'd0, i_field_value);
          r_valid   <= 1'b1;
          r_busy    <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: if (w_accept) begin
          if (w_last) begin
            r_valid     <= 1'b0;
            r_done      <= 1'b1;
            r_msg_count <= r_msg_count + 16'd1;
            r_state     <= S_DONE;
          end else begin
            r_idx     <= r_idx + 8'd1;
            r_tx_data <= char_at(r_idx + 8'd1, r_snap);
          end
        end
        S_DONE: if (r_pending) begin
          // Chain straight into the queued message without passing IDLE.
          r_pending <= 1'b0;
          r_snap    <= i_field_value;
          r_idx     <= '0;
          r_tx_data <= char_at(8'd0, i_field_value);
          r_valid   <= 1'b1;
          r_state   <= S_SEND;
        end else begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Requests while busy. This sits after the DONE branch so that a
      // trigger in the DONE cycle re-arms pending after it has been consumed.
      if (r_state != S_IDLE) begin
        if (i_trigger) r_pending <= 1'b1;
        if (w_tick && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
      end
    end
  end

  assign o_tx_data       = r_tx_data;
  assign o_tx_data_valid = r_valid;
  assign o_busy          = r_busy;
  assign o_msg_done      = r_done;
  assign o_msg_count     = r_msg_count;
  assign o_overrun_cnt   = r_overrun;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
module tb_uart_msg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, en, trig, rdy;
  logic [31:0] fv;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, msg_done;
  logic [15:0] msg_count;
  logic [7:0]  ovr;

  int total = 0;
  int bad   = 0;

  // Ready model: 0 always, 1 one cycle in rdy_n, 2 random, 3 never.
  int rdy_mode = 0;
  int rdy_n    = 1;
  int rcnt     = 0;

  // Monitor state
  logic [7:0] q[$];
  int         acc_cyc[$];
  int         done_cnt = 0;
  int         stab_err = 0;
  int         cyc      = 0;

  uart_msg_sequencer #(.PERIOD_CYCLES(200)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_periodic_en(en), .i_trigger(trig),
    .i_field_value(fv), .o_tx_data(tx_data), .o_tx_data_valid(tx_valid),
    .i_tx_data_ready(rdy), .o_busy(busy), .o_msg_done(msg_done),
    .o_msg_count(msg_count), .o_overrun_cnt(ovr)
  );

  always #5 clk = ~clk;

  initial begin
    rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      rcnt++;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (rcnt % rdy_n == 0);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b0;
      endcase
    end
  end

  // Records accepted bytes, msg_done pulses and tx_data stability under backpressure.
  initial begin
    logic       pv, pacc;
    logic [7:0] pd;
    pv = 1'b0; pacc = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        if (pv && !pacc && tx_valid && tx_data !== pd) stab_err++;
        if (tx_valid && rdy) begin q.push_back(tx_data); acc_cyc.push_back(cyc); end
        if (msg_done) done_cnt++;
      end
      pv = tx_valid; pacc = tx_valid && rdy; pd = tx_data;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0; en = 1'b0; trig = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    q.delete(); acc_cyc.delete(); done_cnt = 0; stab_err = 0;
  endtask

  task automatic pulse_trig();
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit timed_out);
    int c = 0;
    while (done_cnt < n && c < budget) begin @(posedge clk); c++; end
    timed_out = (done_cnt < n);
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit timed_out);
    int c = 0;
    #0;
    while (q.size() < n && c < budget) begin @(posedge clk); #1; c++; end
    timed_out = (q.size() < n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; trig = 1'b0; fv = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (tx_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (msg_done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", msg_done); end
    total++; if (msg_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", msg_count); end
    total++; if (ovr !== 8'd0)        begin bad++; $display("FAIL reset_ovr: got %0d want 0", ovr); end
    total++; if (tx_data !== 8'd0)    begin bad++; $display("FAIL reset_data: got %h want 00", tx_data); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [111:0] e;
    bit to;
    e = "CNT=1A2B3C4D\r\n";
    do_reset(); rdy_mode = 0; fv = 32'h1A2B3C4D;
    pulse_trig();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h43) begin
      bad++; $display("FAIL single_latency: valid=%b data=%h want 1/43", tx_valid, tx_data); end
    wait_done(1, 100, to);
    total++; if (to) begin bad++; $display("FAIL single_timeout: done=%0d want 1", done_cnt); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (q.size() != 14) begin bad++; $display("FAIL single_len: got %0d want 14", q.size()); end
    for (int i = 0; i < 14 && i < q.size(); i++) begin
      total++; if (q[i] !== e[8*(13-i) +: 8]) begin
        bad++; $display("FAIL single_byte%0d: got %h want %h", i, q[i], e[8*(13-i) +: 8]); end
    end
    total++; if (done_cnt != 1)       begin bad++; $display("FAIL single_pulses: got %0d want 1", done_cnt); end
    total++; if (msg_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", msg_count); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_periodic();
    logic [111:0] e;
    int n, first, second;
    e = "CNT=DEADBEEF\r\n";
    do_reset(); rdy_mode = 1; rdy_n = 10; fv = 32'hDEADBEEF;
    @(posedge clk); #1 en = 1'b1;
    n = 0; first = -1; second = -1;
    while (n < 500 && second < 0) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (busy && first < 0) first = n;
      else if (busy && first > 0 && n > first + 150 && second < 0) second = n;
    end
    total++; if (first != 200)  begin bad++; $display("FAIL periodic_first: start edge %0d want 200", first); end
    total++; if (second != 400) begin bad++; $display("FAIL periodic_second: start edge %0d want 400", second); end
    total++; if (msg_count !== 16'd1) begin bad++; $display("FAIL periodic_count: got %0d want 1", msg_count); end
    total++; if (ovr !== 8'd0)        begin bad++; $display("FAIL periodic_ovr: got %0d want 0", ovr); end
    for (int i = 0; i < 14 && i < q.size(); i++) begin
      total++; if (q[i] !== e[8*(13-i) +: 8]) begin
        bad++; $display("FAIL periodic_byte%0d: got %h want %h", i, q[i], e[8*(13-i) +: 8]); end
    end
    en = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset(); rdy_mode = 1; rdy_n = 20; fv = 32'h0;
    @(posedge clk); #1 en = 1'b1;
    repeat (1100) @(posedge clk);
    @(negedge clk);
    total++; if (ovr !== 8'd2)        begin bad++; $display("FAIL overrun_slow: got %0d want 2", ovr); end
    total++; if (msg_count !== 16'd2) begin bad++; $display("FAIL overrun_count: got %0d want 2", msg_count); end
    rdy_mode = 3;  // stall the current message: every tick from here is dropped
    repeat (20000) @(posedge clk);
    @(negedge clk);
    total++; if (ovr !== 8'd102) begin bad++; $display("FAIL overrun_mid: got %0d want 102", ovr); end
    repeat (31000) @(posedge clk);
    @(negedge clk);
    total++; if (ovr !== 8'd255) begin bad++; $display("FAIL overrun_sat: got %0d want 255", ovr); end
    total++; if (busy !== 1'b1 || msg_count !== 16'd2) begin
      bad++; $display("FAIL overrun_hold: busy=%b count=%0d want 1/2", busy, msg_count); end
    en = 1'b0; rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    logic [111:0] e;
    bit to;
    e = "CNT=1A2B3C4D\r\n";
    do_reset(); rdy_mode = 0; fv = 32'h1A2B3C4D;
    pulse_trig();
    wait_bytes(5, 50, to);
    trig = 1'b1; @(posedge clk); #1 trig = 1'b0;
    wait_bytes(9, 50, to);
    trig = 1'b1; @(posedge clk); #1 trig = 1'b0;
    wait_done(2, 200, to);
    total++; if (to) begin bad++; $display("FAIL b2b_timeout: done=%0d want 2", done_cnt); end
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (done_cnt != 2)       begin bad++; $display("FAIL b2b_pulses: got %0d want 2", done_cnt); end
    total++; if (msg_count !== 16'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", msg_count); end
    total++; if (q.size() != 28)      begin bad++; $display("FAIL b2b_len: got %0d want 28", q.size()); end
    total++; if (acc_cyc.size() == 28 && acc_cyc[14] - acc_cyc[13] != 2) begin
      bad++; $display("FAIL b2b_gap: got %0d want 2", acc_cyc[14] - acc_cyc[13]); end
    for (int i = 0; i < 28 && i < q.size(); i++) begin
      total++; if (q[i] !== e[8*(13-(i%14)) +: 8]) begin
        bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, q[i], e[8*(13-(i%14)) +: 8]); end
    end
  endtask

  task automatic test_snapshot();
    logic [111:0] e1, e2;
    bit to;
    e1 = "CNT=1A2B3C4D\r\n";
    e2 = "CNT=FFFFFFFF\r\n";
    do_reset(); rdy_mode = 0; fv = 32'h1A2B3C4D;
    pulse_trig();
    wait_bytes(3, 50, to);
    fv = 32'hFFFFFFFF;
    wait_done(1, 100, to);
    pulse_trig();
    wait_done(2, 100, to);
    total++; if (to) begin bad++; $display("FAIL snap_timeout: done=%0d want 2", done_cnt); end
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 28 && i < q.size(); i++) begin
      total++;
      if (i < 14 ? (q[i] !== e1[8*(13-i) +: 8]) : (q[i] !== e2[8*(27-i) +: 8])) begin
        bad++; $display("FAIL snap_byte%0d: got %h want %h", i, q[i],
                        i < 14 ? e1[8*(13-i) +: 8] : e2[8*(27-i) +: 8]); end
    end
  endtask

  task automatic test_random_ready();
    logic [111:0] e;
    bit to;
    e = "CNT=0F9A5E07\r\n";
    do_reset(); rdy_mode = 2; fv = 32'h0F9A5E07;
    pulse_trig();
    wait_done(1, 1000, to);
    total++; if (to) begin bad++; $display("FAIL rand_timeout: done=%0d want 1", done_cnt); end
    @(posedge clk); @(negedge clk);
    total++; if (q.size() != 14) begin bad++; $display("FAIL rand_len: got %0d want 14", q.size()); end
    total++; if (stab_err != 0)  begin bad++; $display("FAIL rand_stable: changes=%0d want 0", stab_err); end
    for (int i = 0; i < 14 && i < q.size(); i++) begin
      total++; if (q[i] !== e[8*(13-i) +: 8]) begin
        bad++; $display("FAIL rand_byte%0d: got %h want %h", i, q[i], e[8*(13-i) +: 8]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_midreset();
    logic [111:0] e;
    bit to;
    e = "CNT=00C0FFEE\r\n";
    do_reset(); rdy_mode = 0; fv = 32'h1A2B3C4D;
    pulse_trig();
    wait_done(1, 100, to);
    rdy_mode = 3;
    pulse_trig();
    #1 en = 1'b1;
    repeat (205) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    total++; if (ovr !== 8'd1 || msg_count !== 16'd1) begin
      bad++; $display("FAIL midrst_pre: ovr=%0d count=%0d want 1/1", ovr, msg_count); end
    q.delete(); rdy_mode = 0;
    wait_bytes(7, 50, to);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; rdy_mode = 3;
    @(negedge clk);
    total++; if (tx_valid !== 1'b0)   begin bad++; $display("FAIL midrst_valid: got %b want 0", tx_valid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (msg_count !== 16'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", msg_count); end
    total++; if (ovr !== 8'd0)        begin bad++; $display("FAIL midrst_ovr: got %0d want 0", ovr); end
    repeat (5) @(posedge clk);
    q.delete(); done_cnt = 0; fv = 32'h00C0FFEE; rdy_mode = 0;
    pulse_trig();
    wait_done(1, 100, to);
    @(posedge clk); @(negedge clk);
    total++; if (q.size() != 14)      begin bad++; $display("FAIL midrst_len: got %0d want 14", q.size()); end
    total++; if (msg_count !== 16'd1) begin bad++; $display("FAIL midrst_recount: got %0d want 1", msg_count); end
    for (int i = 0; i < 14 && i < q.size(); i++) begin
      total++; if (q[i] !== e[8*(13-i) +: 8]) begin
        bad++; $display("FAIL midrst_byte%0d: got %h want %h", i, q[i], e[8*(13-i) +: 8]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_periodic();
    test_back_to_back();
    test_snapshot();
    test_random_ready();
    test_midreset();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_msg_sequencer.md
Name: uart_msg_sequencer

Overview:
- Parametrised successor to the fixed "Hello World x" UART sender.
- Streams a MSG_LEN-byte message template into the existing uart_tx byte interface (tx_data / tx_data_valid / tx_data_ready).
- Replaces a configurable field of the template with the uppercase ASCII-hex rendering of a live input value.
- Sends on a programmable periodic tick and/or a manual trigger; reports completion, message count and dropped-tick overruns.

Parameters:
- PERIOD_CYCLES, 27_000_000, clk cycles between periodic ticks (>=2).
- MSG_LEN, 14, message length in bytes (1..255).
- MSG_TEMPLATE, "CNT=00000000\r\n", 8*MSG_LEN bits; byte 0 = MSG_TEMPLATE[8*MSG_LEN-1 -: 8] (string order).
- FIELD_POS, 4, index of the first substituted byte.
- FIELD_DIGITS, 8, number of hex digits substituted (1..16); FIELD_POS+FIELD_DIGITS <= MSG_LEN is checked at elaboration.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- periodic_en  in  1  enables the period counter and periodic sends.
- trigger  in  1  single-cycle request for one message.
- field_value  in  4*FIELD_DIGITS  value rendered into the field.
- tx_data  out  8  byte to uart_tx.
- tx_data_valid  out  1  byte valid.
- tx_data_ready  in  1  uart_tx can accept.
- busy  out  1  message in progress.
- msg_done  out  1  one-cycle pulse after the last byte is accepted.
- msg_count  out  16  completed messages, wraps at 0xFFFF->0.
- overrun_cnt  out  8  periodic ticks dropped while busy, saturates at 255.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs and state are 0 and the FSM is in IDLE, including mid-message. tx_data_valid is low after the first reset edge. No partial-message resume.
- Period counter:
  - Counts 0..PERIOD_CYCLES-1 while periodic_en=1; tick is asserted when count==PERIOD_CYCLES-1, then the counter wraps to 0.
  - periodic_en=0 clears the counter to 0 and suppresses ticks.
- Start request: req = trigger | tick.
- FSM states:
  - IDLE: on req, snapshot field_value, set idx=0, busy=1, go to SEND. tx_data_valid=1 with byte 0 in the following cycle (1-cycle latency).
  - SEND: tx_data_valid=1; tx_data = char(idx), stable while valid. A byte is accepted on a cycle with tx_data_valid & tx_data_ready.
    - On accept with idx<MSG_LEN-1: idx++, and the next byte is presented on the next cycle (valid may stay high).
    - On accept with idx==MSG_LEN-1: go to DONE.
  - DONE (1 cycle): tx_data_valid=0, msg_done=1, msg_count++.
    - If pending=1: clear pending, take a new snapshot, idx=0, go to SEND (busy stays 1).
    - Otherwise busy=0 and go to IDLE.
- char(idx):
  - For FIELD_POS <= idx < FIELD_POS+FIELD_DIGITS: nibble k = FIELD_DIGITS-1-(idx-FIELD_POS) of the snapshot (MS nibble first); 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
  - Otherwise the template byte idx.
- Snapshot: field_value changes during a message do not affect it.
- Requests while busy (SEND or DONE):
  - trigger sets pending (1 deep; further triggers are absorbed).
  - A tick sets nothing and increments overrun_cnt (saturating).
  - A tick and trigger in the same busy cycle: pending=1 and overrun_cnt++.
- trigger and tick together in IDLE: exactly one message, no overrun.
- tx_data_ready low for any duration: the FSM holds; no timeout.

Test Plan:
- Defaults with PERIOD_CYCLES=200, periodic_en=0, field_value=32'h1A2B3C4D, one trigger, ready always high -> bytes "CNT=1A2B3C4D\r\n" (0x43 0x4E 0x54 0x3D 0x31 0x41 0x32 0x42 0x33 0x43 0x34 0x44 0x0D 0x0A). Then msg_done pulses once, msg_count=1, busy=0.
- periodic_en=1, PERIOD_CYCLES=200, uart model accepting 1 byte per 10 cycles -> first tick at cycle 199, a message every 200 cycles, overrun_cnt=0. Repeat with 1 byte per 20 cycles (message takes longer than 200 cycles) -> overrun_cnt increments once per tick during busy, and saturates at 255 over a long run.
- Trigger during byte 5, then again during byte 9 -> exactly 2 messages back-to-back (DONE directly to SEND), msg_count=2.
- field_value changed to 32'hFFFFFFFF mid-message -> current message still shows 1A2B3C4D; the next message shows FFFFFFFF.
- tx_data_ready randomly deasserted -> tx_data stable while valid, no byte skipped or duplicated.
- rst_n low for 1 cycle during byte 7 -> tx_data_valid=0, busy=0, msg_count=0, overrun_cnt=0. The next trigger restarts from byte 0.
